// File: rtl/lr_session_ctrl.sv
// Session controller for the linear-regression datapath: owns the single-port dataset RAM
// and hands it in turn to the serial loader, the LR engine (read-only) and the weight write-back.
module lr_session_ctrl #(
  parameter int MAX_FEATURES = 7,
  parameter int DATA_WIDTH   = 16*(MAX_FEATURES+1),
  parameter int ADDR_WIDTH   = 3,
  parameter int NUM_DP       = 6,
  parameter int WB_ADDR      = 2**ADDR_WIDTH-1,
  parameter int EPOCHS       = 1,
  parameter int TIMEOUT      = 4096
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic                  reload,
  input  logic                  abort,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_done,
  output logic                  lr_start,
  input  logic [ADDR_WIDTH-1:0] lr_rd_addr,
  output logic [DATA_WIDTH-1:0] lr_rd_data,
  input  logic                  lr_done,
  input  logic [DATA_WIDTH-1:0] lr_w,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            err_code,
  output logic [7:0]            epoch_cnt
);

  localparam int CNT_W = $clog2(NUM_DP+1);
  localparam int WD_W  = $clog2(TIMEOUT+1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_TRAIN, S_WB, S_DONE, S_ERR} state_t;

  state_t           state;
  logic [CNT_W-1:0] ld_cnt;
  logic [WD_W-1:0]  wdog;
  logic             beat, beat_last, addr_bad, epoch_last, wd_hit;

  assign lr_rd_data = ram_rdata;
  assign beat       = (state == S_LOAD) && ld_valid && ld_ready;
  assign beat_last  = ld_cnt == CNT_W'(NUM_DP-1);
  assign addr_bad   = ld_addr >= ADDR_WIDTH'(NUM_DP);
  assign epoch_last = ({1'b0, epoch_cnt} + 9'd1) >= 9'(EPOCHS);
  assign wd_hit     = (wdog + WD_W'(1)) == WD_W'(TIMEOUT-1);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= S_IDLE;
      ld_cnt    <= '0;
      wdog      <= '0;
      ld_ready  <= 1'b0;
      lr_start  <= 1'b0;
      ram_we    <= 1'b0;
      ram_oe    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_code  <= 2'd0;
      epoch_cnt <= 8'd0;
    end else if (abort) begin
      // a beat accepted in this cycle is dropped: its write would only appear next cycle
      state     <= S_IDLE;
      ld_cnt    <= '0;
      wdog      <= '0;
      ld_ready  <= 1'b0;
      lr_start  <= 1'b0;
      ram_we    <= 1'b0;
      ram_oe    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_code  <= 2'd0;
      epoch_cnt <= 8'd0;
    end else begin
      ram_we   <= 1'b0;
      lr_start <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            done      <= 1'b0;
            err_code  <= 2'd0;
            epoch_cnt <= 8'd0;
            busy      <= 1'b1;
            ld_cnt    <= '0;
            if (reload) begin
              state    <= S_LOAD;
              ld_ready <= 1'b1;
            end else begin
              state    <= S_START;
              lr_start <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (beat && addr_bad) begin
            state    <= S_ERR;
            err_code <= 2'd2;
            ld_ready <= 1'b0;
            busy     <= 1'b0;
          end else if (beat && beat_last) begin
            // last row is written while START pulses lr_start; the engine cannot read yet
            ram_we    <= 1'b1;
            ram_addr  <= ld_addr;
            ram_wdata <= ld_data;
            ld_cnt    <= ld_cnt + CNT_W'(1);
            ld_ready  <= 1'b0;
            lr_start  <= 1'b1;
            state     <= S_START;
          end else if (ld_done) begin
            state    <= S_ERR;
            err_code <= 2'd1;
            ld_ready <= 1'b0;
            busy     <= 1'b0;
          end else if (beat) begin
            ram_we    <= 1'b1;
            ram_addr  <= ld_addr;
            ram_wdata <= ld_data;
            ld_cnt    <= ld_cnt + CNT_W'(1);
          end
        end
        S_START: begin
          state    <= S_TRAIN;
          wdog     <= '0;
          ram_oe   <= 1'b1;
          ram_addr <= lr_rd_addr;
        end
        S_TRAIN: begin
          if (lr_done) begin
            epoch_cnt <= epoch_cnt + 8'd1;
            ram_oe    <= 1'b0;
            if (epoch_last) begin
              state     <= S_WB;
              ram_we    <= 1'b1;
              ram_addr  <= ADDR_WIDTH'(WB_ADDR);
              ram_wdata <= lr_w;
            end else begin
              state    <= S_START;
              lr_start <= 1'b1;
            end
          end else if (wd_hit) begin
            state    <= S_ERR;
            err_code <= 2'd3;
            ram_oe   <= 1'b0;
            busy     <= 1'b0;
          end else begin
            wdog     <= wdog + WD_W'(1);
            ram_addr <= lr_rd_addr;
          end
        end
        S_WB: begin
          state <= S_DONE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        S_ERR: ;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lr_session_ctrl.sv
// Bench for lr_session_ctrl: instance 0 runs single-epoch sessions, instance 1 runs
// three epochs with a 16-cycle watchdog; each drives its own behavioural RAM.
`timescale 1ns/1ps
module tb_lr_session_ctrl;
  localparam int DW  = 128;
  localparam int AW  = 3;
  localparam int NDP = 6;
  localparam int WBA = 7;
  localparam int EP1 = 3;
  localparam int TO1 = 16;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  logic          start [2], reload [2], abort [2], ld_valid [2], ld_done [2], lr_done [2];
  logic [AW-1:0] ld_addr [2], lr_rd_addr [2], ram_addr [2];
  logic [DW-1:0] ld_data [2], lr_w [2], lr_rd_data [2], ram_wdata [2], ram_rdata [2];
  logic          ld_ready [2], lr_start [2], ram_we [2], ram_oe [2], busy [2], done [2];
  logic [1:0]    err_code [2];
  logic [7:0]    epoch_cnt [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    lr_session_ctrl #(.EPOCHS(g == 0 ? 1 : EP1), .TIMEOUT(g == 0 ? 4096 : TO1)) u_dut (
      .CLK(CLK), .RST(RST), .start(start[g]), .reload(reload[g]), .abort(abort[g]),
      .ld_valid(ld_valid[g]), .ld_ready(ld_ready[g]), .ld_addr(ld_addr[g]), .ld_data(ld_data[g]),
      .ld_done(ld_done[g]), .lr_start(lr_start[g]), .lr_rd_addr(lr_rd_addr[g]),
      .lr_rd_data(lr_rd_data[g]), .lr_done(lr_done[g]), .lr_w(lr_w[g]), .ram_we(ram_we[g]),
      .ram_oe(ram_oe[g]), .ram_addr(ram_addr[g]), .ram_wdata(ram_wdata[g]),
      .ram_rdata(ram_rdata[g]), .busy(busy[g]), .done(done[g]), .err_code(err_code[g]),
      .epoch_cnt(epoch_cnt[g]));
  end

  // RAM per instance, plus write and lr_start-cycle counters
  logic [DW-1:0] mem [2][8];
  int wr_cnt [2];
  int ls_cnt [2];
  always @(posedge CLK) begin
    for (int g = 0; g < 2; g++) begin
      if (ram_we[g]) begin
        mem[g][ram_addr[g]] <= ram_wdata[g];
        wr_cnt[g] <= wr_cnt[g] + 1;
      end
      if (lr_start[g]) ls_cnt[g] <= ls_cnt[g] + 1;
    end
  end
  always_comb begin
    for (int g = 0; g < 2; g++) ram_rdata[g] = ram_oe[g] ? mem[g][ram_addr[g]] : '0;
  end

  // reference model: what each RAM row should hold
  logic [DW-1:0] ref_mem [2][8];
  bit            ref_vld [2][8];
  int n_chk = 0;
  int n_err = 0;
  int wr0, ls0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_row();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check_zero(input int s, input string tag);
    check({tag, "_busy"}, DW'(busy[s]), '0);
    check({tag, "_done"}, DW'(done[s]), '0);
    check({tag, "_err"}, DW'(err_code[s]), '0);
    check({tag, "_epoch"}, DW'(epoch_cnt[s]), '0);
    check({tag, "_ld_ready"}, DW'(ld_ready[s]), '0);
    check({tag, "_lr_start"}, DW'(lr_start[s]), '0);
    check({tag, "_ram_we"}, DW'(ram_we[s]), '0);
    check({tag, "_ram_oe"}, DW'(ram_oe[s]), '0);
    check({tag, "_ram_addr"}, DW'(ram_addr[s]), '0);
    check({tag, "_ram_wdata"}, ram_wdata[s], '0);
  endtask

  task automatic snap(input int s);
    wr0 = wr_cnt[s];
    ls0 = ls_cnt[s];
  endtask

  task automatic do_start(input int s, input bit rl, input string tag);
    start[s] = 1'b1; reload[s] = rl;
    tick();
    start[s] = 1'b0; reload[s] = 1'b0;
    check({tag, "_start_busy"}, DW'(busy[s]), DW'(1));
    check({tag, "_start_ld_ready"}, DW'(ld_ready[s]), DW'(rl));
    check({tag, "_start_lr_start"}, DW'(lr_start[s]), DW'(!rl));
    check({tag, "_start_clr"}, DW'({done[s], err_code[s], epoch_cnt[s]}), '0);
  endtask

  task automatic send_beat(input int s, input int a, input logic [DW-1:0] d, input string tag);
    repeat ($urandom_range(0, 2)) tick();
    ld_valid[s] = 1'b1; ld_addr[s] = AW'(a); ld_data[s] = d;
    tick();
    ld_valid[s] = 1'b0;
    if (a < NDP) begin
      check({tag, "_wr_we"}, DW'(ram_we[s]), DW'(1));
      check({tag, "_wr_addr"}, DW'(ram_addr[s]), DW'(a));
      check({tag, "_wr_data"}, ram_wdata[s], d);
      ref_mem[s][a] = d;
      ref_vld[s][a] = 1'b1;
    end else begin
      check({tag, "_bad_err"}, DW'(err_code[s]), DW'(2));
      check({tag, "_bad_idle"}, DW'({busy[s], ld_ready[s], ram_we[s]}), '0);
    end
  endtask

  // entered with lr_start visible; reads for 'reads' cycles then pulses lr_done
  task automatic train_epoch(input int s, input int reads, input bit fin,
                             input logic [DW-1:0] w, input int ep, input string tag);
    int a;
    check({tag, "_lr_start"}, DW'(lr_start[s]), DW'(1));
    for (int i = 0; i < reads; i++) begin
      a = $urandom_range(0, NDP-1);
      lr_rd_addr[s] = AW'(a);
      tick();
      check({tag, "_rd_data"}, lr_rd_data[s], ref_mem[s][a]);
      check({tag, "_rd_ctl"}, DW'({ram_oe[s], ram_we[s], lr_start[s], busy[s]}), DW'(4'b1001));
    end
    lr_done[s] = 1'b1; lr_w[s] = w;
    tick();
    lr_done[s] = 1'b0; lr_w[s] = '0;
    check({tag, "_epoch"}, DW'(epoch_cnt[s]), DW'(ep + 1));
    if (fin) begin
      check({tag, "_wb_we"}, DW'(ram_we[s]), DW'(1));
      check({tag, "_wb_addr"}, DW'(ram_addr[s]), DW'(WBA));
      check({tag, "_wb_data"}, ram_wdata[s], w);
      ref_mem[s][WBA] = w;
      ref_vld[s][WBA] = 1'b1;
      tick();
      check({tag, "_done"}, DW'({done[s], busy[s], ram_we[s], ram_oe[s]}), DW'(4'b1000));
      check({tag, "_err"}, DW'(err_code[s]), '0);
    end else begin
      check({tag, "_next_epoch"}, DW'({lr_start[s], ram_we[s], busy[s]}), DW'(3'b101));
    end
  endtask

  task automatic verify_mem(input int s, input string tag);
    for (int a = 0; a < 8; a++)
      if (ref_vld[s][a]) check({tag, "_row"}, mem[s][a], ref_mem[s][a]);
  endtask

  task automatic do_abort(input int s, input string tag);
    abort[s] = 1'b1;
    tick();
    abort[s] = 1'b0;
    check({tag, "_abort"}, DW'({busy[s], done[s], err_code[s], epoch_cnt[s], ram_we[s]}), '0);
  endtask

  initial begin
    #100000;
    $fatal(1, "FAIL global_timeout: simulation did not finish");
  end

  initial begin
    int perm [NDP];
    int n, t;
    logic [DW-1:0] w;
    for (int s = 0; s < 2; s++) begin
      start[s] = 0; reload[s] = 0; abort[s] = 0; ld_valid[s] = 0; ld_done[s] = 0;
      lr_done[s] = 0; ld_addr[s] = '0; lr_rd_addr[s] = '0; ld_data[s] = '0; lr_w[s] = '0;
    end
    RST = 1'b0;
    tick(); tick();
    check_zero(0, "rst0");
    check_zero(1, "rst1");
    RST = 1'b1;
    tick();

    // T1: in-order load, one epoch, lr_done 20 cycles after lr_start
    snap(0);
    do_start(0, 1'b1, "t1");
    for (int a = 0; a < NDP; a++) send_beat(0, a, rnd_row(), "t1");
    w = rnd_row();
    train_epoch(0, 19, 1'b1, w, 0, "t1");
    repeat (3) tick();
    check("t1_done_hold", DW'(done[0]), DW'(1));
    check("t1_writes", DW'(wr_cnt[0] - wr0), DW'(NDP + 1));
    check("t1_lr_starts", DW'(ls_cnt[0] - ls0), DW'(1));
    verify_mem(0, "t1");

    // restart from DONE reusing data
    snap(0);
    do_start(0, 1'b0, "t1b");
    train_epoch(0, $urandom_range(3, 10), 1'b1, rnd_row(), 0, "t1b");
    check("t1b_writes", DW'(wr_cnt[0] - wr0), DW'(1));
    verify_mem(0, "t1b");

    // T2: shuffled load then three epochs, followed by a reuse session
    for (int i = 0; i < NDP; i++) perm[i] = i;
    for (int i = NDP-1; i > 0; i--) begin
      n = $urandom_range(0, i); t = perm[i]; perm[i] = perm[n]; perm[n] = t;
    end
    do_start(1, 1'b1, "t2l");
    for (int i = 0; i < NDP; i++) send_beat(1, perm[i], rnd_row(), "t2l");
    for (int e = 0; e < EP1; e++) train_epoch(1, $urandom_range(1, 14), e == EP1-1, rnd_row(), e, "t2l");
    snap(1);
    do_start(1, 1'b0, "t2");
    for (int e = 0; e < EP1; e++) train_epoch(1, $urandom_range(1, 14), e == EP1-1, rnd_row(), e, "t2");
    check("t2_epoch_cnt", DW'(epoch_cnt[1]), DW'(EP1));
    check("t2_lr_starts", DW'(ls_cnt[1] - ls0), DW'(EP1));
    check("t2_writes", DW'(wr_cnt[1] - wr0), DW'(1));
    verify_mem(1, "t2");

    // T4: watchdog expiry, then lr_done landing on the expiry cycle
    snap(1);
    do_start(1, 1'b0, "t4");
    n = 0;
    while (err_code[1] !== 2'd3 && n < 40) begin
      lr_rd_addr[1] = AW'($urandom_range(0, NDP-1));
      tick();
      n++;
    end
    check("t4_wd_cycles", DW'(n), DW'(TO1));
    check("t4_err_idle", DW'({busy[1], ram_oe[1], ram_we[1], done[1]}), '0);
    start[1] = 1'b1; reload[1] = 1'b1;
    tick();
    start[1] = 1'b0; reload[1] = 1'b0;
    tick();
    check("t4_start_ignored", DW'({busy[1], ld_ready[1], lr_start[1]}), '0);
    check("t4_err_held", DW'(err_code[1]), DW'(3));
    check("t4_no_wb", DW'(wr_cnt[1] - wr0), '0);
    do_abort(1, "t4");
    do_start(1, 1'b0, "t4b");
    for (int e = 0; e < EP1; e++) train_epoch(1, TO1 - 1, e == EP1-1, rnd_row(), e, "t4b");
    verify_mem(1, "t4b");

    // T3: out-of-range address in the third beat
    snap(0);
    do_start(0, 1'b1, "t3");
    send_beat(0, 0, rnd_row(), "t3");
    send_beat(0, 1, rnd_row(), "t3");
    send_beat(0, 6, rnd_row(), "t3");
    start[0] = 1'b1; reload[0] = 1'b0;
    tick();
    start[0] = 1'b0;
    check("t3_start_ignored", DW'({busy[0], lr_start[0]}), '0);
    check("t3_err_held", DW'(err_code[0]), DW'(2));
    check("t3_writes", DW'(wr_cnt[0] - wr0), DW'(2));
    do_abort(0, "t3");
    verify_mem(0, "t3");

    // T5: loader ends early
    snap(0);
    do_start(0, 1'b1, "t5");
    for (int a = 2; a < NDP; a++) send_beat(0, a, rnd_row(), "t5");
    ld_done[0] = 1'b1;
    tick();
    ld_done[0] = 1'b0;
    check("t5_err", DW'(err_code[0]), DW'(1));
    check("t5_idle", DW'({busy[0], ld_ready[0]}), '0);
    tick();
    check("t5_writes", DW'(wr_cnt[0] - wr0), DW'(4));
    do_abort(0, "t5");

    // reset during TRAIN
    do_start(0, 1'b0, "t5r");
    repeat (4) begin
      lr_rd_addr[0] = AW'($urandom_range(0, NDP-1));
      tick();
    end
    check("t5r_in_train", DW'(ram_oe[0]), DW'(1));
    RST = 1'b0;
    tick();
    check_zero(0, "t5r");
    check("t5r_rd_data", lr_rd_data[0], '0);
    RST = 1'b1;
    tick();
    verify_mem(0, "t5r");

    // T6: abort on the cycle a beat is accepted
    snap(0);
    do_start(0, 1'b1, "t6");
    ld_valid[0] = 1'b1; ld_addr[0] = 3'd0; ld_data[0] = rnd_row(); abort[0] = 1'b1;
    tick();
    ld_valid[0] = 1'b0; abort[0] = 1'b0;
    check("t6_idle", DW'({busy[0], ld_ready[0], ram_we[0], err_code[0]}), '0);
    tick();
    check("t6_no_write", DW'(wr_cnt[0] - wr0), '0);
    verify_mem(0, "t6");
    do_start(0, 1'b0, "t6r");
    do_abort(0, "t6r");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
